// File: rtl/control_fsm.sv
// Multicycle MIPS-style control unit.
// Moore FSM: every control output is decoded from the registered state.
// A few outputs also qualify on a flag that is valid in that same state
// (alu_eq, overflow, div_done/div_zero).
// MEM_WAIT sets how many cycles a memory read needs.
module control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_eq,
  input  logic       overflow,
  input  logic       div_done,
  input  logic       div_zero,
  output logic       PC_write,
  output logic       wr,
  output logic       sel_ir,
  output logic       AB_load,
  output logic       aluout_load,
  output logic       regwrite,
  output logic       EPC_load,
  output logic       HiLo_load,
  output logic       div_start,
  output logic       sel_alusrca,
  output logic [1:0] sel_alusrcb,
  output logic [2:0] alu_op,
  output logic [2:0] sel_mux_iord,
  output logic [1:0] sel_regdst,
  output logic [3:0] sel_mux_mem_to_reg,
  output logic [1:0] sel_pc_source,
  output logic [4:0] state_out
);

  localparam int CW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_WAIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  // Memory address selects; the last three also serve as exception codes.
  localparam logic [2:0] IORD_PC      = 3'd0;
  localparam logic [2:0] IORD_ALUOUT  = 3'd1;
  localparam logic [2:0] EXC_ILLEGAL  = 3'd2;
  localparam logic [2:0] EXC_OVERFLOW = 3'd3;
  localparam logic [2:0] EXC_DIVZERO  = 3'd4;

  typedef enum logic [4:0] {
    ST_RST       = 5'd0,
    ST_FETCH     = 5'd1,
    ST_FWAIT     = 5'd2,
    ST_DECODE    = 5'd3,
    ST_R_EXEC    = 5'd4,
    ST_R_WB      = 5'd5,
    ST_ADDI_EXEC = 5'd6,
    ST_ADDI_WB   = 5'd7,
    ST_MEM_ADDR  = 5'd8,
    ST_LW_WAIT   = 5'd9,
    ST_LW_WB     = 5'd10,
    ST_SW_WR     = 5'd11,
    ST_BRANCH    = 5'd12,
    ST_JUMP      = 5'd13,
    ST_DIV_START = 5'd14,
    ST_DIV_WAIT  = 5'd15,
    ST_EXC_SAVE  = 5'd16,
    ST_EXC_WAIT  = 5'd17,
    ST_EXC_JUMP  = 5'd18
  } state_t;

  // Instruction class captured at decode so later states need not re-decode IR.
  typedef enum logic [2:0] {
    K_ADD  = 3'd0,
    K_SUB  = 3'd1,
    K_AND  = 3'd2,
    K_ADDI = 3'd3,
    K_LW   = 3'd4,
    K_SW   = 3'd5,
    K_BEQ  = 3'd6,
    K_BNE  = 3'd7
  } kind_t;

  state_t        state_r, state_nxt_s;
  kind_t         kind_r, kind_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_dec_s;
  logic [2:0]    code_r, code_nxt_s;
  logic          ovf_trap_s;

  assign state_out  = state_r;
  // Saturating decrement keeps a corrupted zero count from wrapping.
  assign cnt_dec_s  = (cnt_r == CNT_ZERO) ? CNT_ZERO : (cnt_r - CNT_ONE);
  // and never traps; add/sub trap on signed overflow.
  assign ovf_trap_s = overflow && ((kind_r == K_ADD) || (kind_r == K_SUB));

  // State, wait counter, instruction class and exception code registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RST;
      cnt_r   <= CNT_ZERO;
      kind_r  <= K_ADD;
      code_r  <= IORD_PC;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      kind_r  <= kind_nxt_s;
      code_r  <= code_nxt_s;
    end
  end

  // Next-state logic and state-decoded control outputs.
  always_comb begin
    state_nxt_s        = state_r;
    cnt_nxt_s          = cnt_r;
    kind_nxt_s         = kind_r;
    code_nxt_s         = code_r;
    PC_write           = 1'b0;
    wr                 = 1'b0;
    sel_ir             = 1'b0;
    AB_load            = 1'b0;
    aluout_load        = 1'b0;
    regwrite           = 1'b0;
    EPC_load           = 1'b0;
    HiLo_load          = 1'b0;
    div_start          = 1'b0;
    sel_alusrca        = 1'b0;
    sel_alusrcb        = 2'b00;
    alu_op             = 3'b000;
    sel_mux_iord       = IORD_PC;
    sel_regdst         = 2'b00;
    sel_mux_mem_to_reg = 4'b0000;
    sel_pc_source      = 2'b00;

    case (state_r)
      ST_RST: begin
        state_nxt_s = ST_FETCH;
      end

      ST_FETCH: begin
        sel_alusrcb = 2'b01;
        alu_op      = ALU_ADD;
        cnt_nxt_s   = CNT_LOAD;
        state_nxt_s = ST_FWAIT;
      end

      // PC+4 stays on the ALU while memory returns the instruction.
      ST_FWAIT: begin
        sel_alusrcb = 2'b01;
        alu_op      = ALU_ADD;
        cnt_nxt_s   = cnt_dec_s;
        if (cnt_r <= CNT_ONE) begin
          sel_ir        = 1'b1;
          PC_write      = 1'b1;
          sel_pc_source = 2'b00;
          state_nxt_s   = ST_DECODE;
        end else begin
          state_nxt_s   = ST_FWAIT;
        end
      end

      // Read registers and compute the branch target in parallel.
      ST_DECODE: begin
        AB_load     = 1'b1;
        aluout_load = 1'b1;
        sel_alusrcb = 2'b11;
        alu_op      = ALU_ADD;
        case (opcode)
          6'h00: begin
            case (funct)
              6'h20: begin kind_nxt_s = K_ADD; state_nxt_s = ST_R_EXEC; end
              6'h22: begin kind_nxt_s = K_SUB; state_nxt_s = ST_R_EXEC; end
              6'h24: begin kind_nxt_s = K_AND; state_nxt_s = ST_R_EXEC; end
              6'h1A: begin state_nxt_s = ST_DIV_START; end
              default: begin code_nxt_s = EXC_ILLEGAL; state_nxt_s = ST_EXC_SAVE; end
            endcase
          end
          6'h08: begin kind_nxt_s = K_ADDI; state_nxt_s = ST_ADDI_EXEC; end
          6'h23: begin kind_nxt_s = K_LW;   state_nxt_s = ST_MEM_ADDR; end
          6'h2B: begin kind_nxt_s = K_SW;   state_nxt_s = ST_MEM_ADDR; end
          6'h04: begin kind_nxt_s = K_BEQ;  state_nxt_s = ST_BRANCH; end
          6'h05: begin kind_nxt_s = K_BNE;  state_nxt_s = ST_BRANCH; end
          6'h02: begin state_nxt_s = ST_JUMP; end
          default: begin code_nxt_s = EXC_ILLEGAL; state_nxt_s = ST_EXC_SAVE; end
        endcase
      end

      ST_R_EXEC: begin
        sel_alusrca = 1'b1;
        sel_alusrcb = 2'b00;
        aluout_load = 1'b1;
        case (kind_r)
          K_SUB:   alu_op = ALU_SUB;
          K_AND:   alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
        state_nxt_s = ST_R_WB;
      end

      ST_R_WB: begin
        sel_regdst         = 2'b01;
        sel_mux_mem_to_reg = 4'b0000;
        if (ovf_trap_s) begin
          code_nxt_s  = EXC_OVERFLOW;
          state_nxt_s = ST_EXC_SAVE;
        end else begin
          regwrite    = 1'b1;
          state_nxt_s = ST_FETCH;
        end
      end

      ST_ADDI_EXEC: begin
        sel_alusrca = 1'b1;
        sel_alusrcb = 2'b10;
        alu_op      = ALU_ADD;
        aluout_load = 1'b1;
        state_nxt_s = ST_ADDI_WB;
      end

      ST_ADDI_WB: begin
        sel_regdst         = 2'b00;
        sel_mux_mem_to_reg = 4'b0000;
        if (overflow) begin
          code_nxt_s  = EXC_OVERFLOW;
          state_nxt_s = ST_EXC_SAVE;
        end else begin
          regwrite    = 1'b1;
          state_nxt_s = ST_FETCH;
        end
      end

      ST_MEM_ADDR: begin
        sel_alusrca = 1'b1;
        sel_alusrcb = 2'b10;
        alu_op      = ALU_ADD;
        aluout_load = 1'b1;
        if (kind_r == K_LW) begin
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = ST_LW_WAIT;
        end else begin
          state_nxt_s = ST_SW_WR;
        end
      end

      ST_LW_WAIT: begin
        sel_mux_iord = IORD_ALUOUT;
        cnt_nxt_s    = cnt_dec_s;
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = ST_LW_WB;
        end else begin
          state_nxt_s = ST_LW_WAIT;
        end
      end

      ST_LW_WB: begin
        sel_regdst         = 2'b00;
        sel_mux_mem_to_reg = 4'b0001;
        regwrite           = 1'b1;
        state_nxt_s        = ST_FETCH;
      end

      ST_SW_WR: begin
        sel_mux_iord = IORD_ALUOUT;
        wr           = 1'b1;
        state_nxt_s  = ST_FETCH;
      end

      // ALUOut already holds the target computed during decode.
      ST_BRANCH: begin
        sel_alusrca   = 1'b1;
        sel_alusrcb   = 2'b00;
        alu_op        = ALU_SUB;
        sel_pc_source = 2'b01;
        PC_write      = ((kind_r == K_BEQ) && alu_eq) || ((kind_r == K_BNE) && !alu_eq);
        state_nxt_s   = ST_FETCH;
      end

      ST_JUMP: begin
        PC_write      = 1'b1;
        sel_pc_source = 2'b10;
        state_nxt_s   = ST_FETCH;
      end

      ST_DIV_START: begin
        div_start   = 1'b1;
        state_nxt_s = ST_DIV_WAIT;
      end

      ST_DIV_WAIT: begin
        if (div_done) begin
          if (div_zero) begin
            code_nxt_s  = EXC_DIVZERO;
            state_nxt_s = ST_EXC_SAVE;
          end else begin
            HiLo_load   = 1'b1;
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_DIV_WAIT;
        end
      end

      // PC already advanced by 4, so EPC takes PC-4.
      ST_EXC_SAVE: begin
        sel_alusrcb = 2'b01;
        alu_op      = ALU_SUB;
        EPC_load    = 1'b1;
        cnt_nxt_s   = CNT_LOAD;
        state_nxt_s = ST_EXC_WAIT;
      end

      // Read the handler address byte from the code-selected constant address.
      ST_EXC_WAIT: begin
        sel_mux_iord = code_r;
        cnt_nxt_s    = cnt_dec_s;
        if (cnt_r <= CNT_ONE) begin
          state_nxt_s = ST_EXC_JUMP;
        end else begin
          state_nxt_s = ST_EXC_WAIT;
        end
      end

      ST_EXC_JUMP: begin
        PC_write      = 1'b1;
        sel_pc_source = 2'b11;
        state_nxt_s   = ST_FETCH;
      end

      default: begin
        state_nxt_s = ST_RST;
      end
    endcase
  end

endmodule
